// File: rtl/ctrl_desplazamiento_pkg.sv
// rtl/ctrl_desplazamiento_pkg.sv - shared state codes and default sizes for the shift sequencer
package ctrl_desplazamiento_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int CNT_W_DEF = 3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SHIFT   = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    function automatic logic is_busy(input state_t s);
        return (s != S_IDLE);
    endfunction

endpackage

// File: rtl/ctrl_desplazamiento_contador.sv
// rtl/ctrl_desplazamiento_contador.sv - loadable down-counter with zero/one flags, never wraps
module contador_desplaz #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero,
    output logic             one
);

    // Load has priority; a decrement at zero is dropped so the count never wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);
    assign one  = (count == CNT_W'(1));

endmodule

// File: rtl/ctrl_desplazamiento.sv
// rtl/ctrl_desplazamiento.sv - load/shift/capture sequencer for the arithmetic-right-shift register
module ctrl_desplazamiento
    import ctrl_desplazamiento_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] operand,
    input  logic [CNT_W-1:0] amount,
    input  logic [WIDTH-1:0] reg_q,
    output logic             reg_load,
    output logic             reg_shift,
    output logic [WIDTH-1:0] reg_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             capture;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_zero;
    logic             cnt_one;

    contador_desplaz #(
        .CNT_W (CNT_W)
    ) u_contador (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (amount),
        .dec      (cnt_dec),
        .count    (cnt_val),
        .zero     (cnt_zero),
        .one      (cnt_one)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus Moore strobes; abort overrides everything outside IDLE
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        cnt_dec   = 1'b0;
        reg_load  = 1'b0;
        reg_shift = 1'b0;
        done      = 1'b0;
        busy      = is_busy(state);
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    accept    = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                reg_load  = 1'b1;
                state_nxt = cnt_zero ? S_CAPTURE : S_SHIFT;
            end
            S_SHIFT: begin
                reg_shift = 1'b1;
                cnt_dec   = 1'b1;
                if (cnt_one || cnt_zero) begin
                    state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                capture   = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (abort && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
            capture   = 1'b0;
            cnt_dec   = 1'b0;
        end
    end

    // Operand latch on accepted start, result capture from the register output
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_data <= '0;
            result   <= '0;
        end else begin
            if (accept) begin
                reg_data <= operand;
            end
            if (capture) begin
                result <= reg_q;
            end
        end
    end

    logic unused_cnt;
    assign unused_cnt = ^cnt_val;

endmodule
